// File: rtl/register_file_hs.sv
// register_file_hs: parametrised register file with NumRead read ports and one
// write port, each handshaked with its own four-phase req/ack pair.
// Read data is registered at capture and held until the port's next capture.
// Optional macro RF_WRITE_BYPASS_EN: a read captured on the same edge as a write
// to the same (stored) address returns the incoming write data instead of the
// old contents.
module register_file_hs #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5,
  parameter int NumRead   = 2,
  parameter int ZeroReg   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumRead-1:0]             req_r_i,
  input  logic [NumRead*AddrWidth-1:0]   raddr_i,
  output logic [NumRead-1:0]             ack_r_o,
  output logic [NumRead*DataWidth-1:0]   rdata_o,
  input  logic                           req_w_i,
  input  logic [AddrWidth-1:0]           waddr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  output logic                           ack_w_o
);

  localparam int Depth = 2 ** AddrWidth;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];
  logic [0:0]           wstate_q, wstate_d;
  logic                 w_fire;
  logic                 w_store;

  // Write port: commit on the IDLE->ACK edge only; register 0 stays untouched when hardwired.
  always_comb begin
    w_fire   = (wstate_q == ST_IDLE) && req_w_i;
    w_store  = w_fire && !((ZeroReg != 0) && (waddr_i == '0));
    wstate_d = req_w_i ? ST_ACK : ST_IDLE;
    mem_d    = mem_q;
    if (w_store) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Write FSM and storage state; reset clears every register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wstate_q <= ST_IDLE;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wstate_q <= wstate_d;
      mem_q    <= mem_d;
    end
  end

  assign ack_w_o = (wstate_q == ST_ACK);

  for (genvar k = 0; k < NumRead; k++) begin : g_rd
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] rd_val;
    logic [0:0]           state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d;

    assign addr = raddr_i[k*AddrWidth +: AddrWidth];

    // Read port: select the value to capture and hold it outside the capture edge.
    always_comb begin
      rd_val = mem_q[addr];
`ifdef RF_WRITE_BYPASS_EN
      if (w_store && (waddr_i == addr)) begin
        rd_val = wdata_i;
      end
`endif
      if ((ZeroReg != 0) && (addr == '0)) begin
        rd_val = '0;
      end
      state_d = req_r_i[k] ? ST_ACK : ST_IDLE;
      data_d  = data_q;
      if ((state_q == ST_IDLE) && req_r_i[k]) begin
        data_d = rd_val;
      end
    end

    // Read FSM and held read data.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q <= ST_IDLE;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
      end
    end

    assign ack_r_o[k]                         = (state_q == ST_ACK);
    assign rdata_o[k*DataWidth +: DataWidth]  = data_q;
  end

endmodule

// File: tb/tb_register_file_hs.sv
// Testbench for register_file_hs with four read ports.
module tb_register_file_hs;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req_r;
  logic [NR*AW-1:0]  raddr;
  logic [NR-1:0]     ack_r;
  logic [NR*DW-1:0]  rdata;
  logic              req_w;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              ack_w;

  register_file_hs #(.DataWidth(DW), .AddrWidth(AW), .NumRead(NR), .ZeroReg(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_r_i(req_r), .raddr_i(raddr), .ack_r_o(ack_r), .rdata_o(rdata),
    .req_w_i(req_w), .waddr_i(waddr), .wdata_i(wdata), .ack_w_o(ack_w)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: storage array, last sampled req per port, held read data.
  logic [DW-1:0] m_mem [32];
  logic          m_ack_w;
  logic [NR-1:0] m_ack_r;
  logic [DW-1:0] m_rd [NR];

  task automatic model_edge();
    logic [DW-1:0] nxt [NR];
    logic [AW-1:0] ra;
    bit wr;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      for (int k = 0; k < NR; k++) m_rd[k] = '0;
      m_ack_w = 1'b0;
      m_ack_r = '0;
    end else begin
      wr = req_w && !m_ack_w;
      for (int k = 0; k < NR; k++) begin
        ra = raddr[k*AW +: AW];
        nxt[k] = m_rd[k];
        if (req_r[k] && !m_ack_r[k]) begin
          if (ra == 0)                          nxt[k] = '0;
          else if (BYP && wr && (waddr == ra))  nxt[k] = wdata;
          else                                  nxt[k] = m_mem[ra];
        end
      end
      if (wr && (waddr != 0)) m_mem[waddr] = wdata;
      m_ack_w = req_w;
      m_ack_r = req_r;
      for (int k = 0; k < NR; k++) m_rd[k] = nxt[k];
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] port_data(input int k);
    return rdata[k*DW +: DW];
  endfunction

  task automatic chk_model(input string nm);
    chk({nm, ".ack_w"}, ack_w, m_ack_w);
    chk({nm, ".ack_r"}, ack_r, m_ack_r);
    for (int k = 0; k < NR; k++) chk($sformatf("%s.rdata%0d", nm, k), port_data(k), m_rd[k]);
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  typedef struct {
    bit            rw;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NR-1:0] rr;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    bit            eaw;
    logic [NR-1:0] ear;
    logic [DW-1:0] ed0;
    logic [DW-1:0] ed1;
  } vec_t;

  function automatic vec_t mk(bit rw, int wa, logic [DW-1:0] wd, logic [NR-1:0] rr, int ra0, int ra1,
                              bit eaw, logic [NR-1:0] ear, logic [DW-1:0] ed0, logic [DW-1:0] ed1);
    vec_t v;
    v.rw = rw; v.wa = wa[AW-1:0]; v.wd = wd; v.rr = rr; v.ra0 = ra0[AW-1:0]; v.ra1 = ra1[AW-1:0];
    v.eaw = eaw; v.ear = ear; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  vec_t tv [20];

  initial begin
    logic [DW-1:0] byp_v;
    logic [DW-1:0] vals [4];
    byp_v = BYP ? 32'h12345678 : 32'hA5A5A5A5;

    tv[0]  = mk(1, 4, 32'h00000001, 4'b0000, 0, 0, 1, 4'b0000, 32'h0, 32'h0);
    tv[1]  = mk(0, 4, 32'h00000001, 4'b0000, 0, 0, 0, 4'b0000, 32'h0, 32'h0);
    tv[2]  = mk(1, 2, 32'h000C0001, 4'b0000, 0, 0, 1, 4'b0000, 32'h0, 32'h0);
    tv[3]  = mk(0, 2, 32'h000C0001, 4'b0000, 0, 0, 0, 4'b0000, 32'h0, 32'h0);
    tv[4]  = mk(0, 0, 32'h0,        4'b0011, 4, 2, 0, 4'b0011, 32'h1, 32'h000C0001);
    tv[5]  = mk(1, 4, 32'hDEADBEEF, 4'b0001, 9, 2, 1, 4'b0001, 32'h1, 32'h000C0001);
    tv[6]  = mk(1, 4, 32'hDEADBEEF, 4'b0001, 9, 2, 1, 4'b0001, 32'h1, 32'h000C0001);
    tv[7]  = mk(0, 4, 32'hDEADBEEF, 4'b0001, 9, 2, 0, 4'b0001, 32'h1, 32'h000C0001);
    tv[8]  = mk(0, 4, 32'hDEADBEEF, 4'b0001, 9, 2, 0, 4'b0001, 32'h1, 32'h000C0001);
    tv[9]  = mk(0, 0, 32'h0,        4'b0000, 9, 2, 0, 4'b0000, 32'h1, 32'h000C0001);
    tv[10] = mk(1, 0, 32'hFFFFFFFF, 4'b0000, 0, 0, 1, 4'b0000, 32'h1, 32'h000C0001);
    tv[11] = mk(0, 0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 4'b0000, 32'h1, 32'h000C0001);
    tv[12] = mk(0, 0, 32'h0,        4'b0011, 0, 4, 0, 4'b0011, 32'h0, 32'hDEADBEEF);
    tv[13] = mk(0, 0, 32'h0,        4'b0000, 0, 4, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
    tv[14] = mk(1, 7, 32'hA5A5A5A5, 4'b0000, 0, 0, 1, 4'b0000, 32'h0, 32'hDEADBEEF);
    tv[15] = mk(0, 7, 32'hA5A5A5A5, 4'b0000, 0, 0, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
    tv[16] = mk(1, 7, 32'h12345678, 4'b0001, 7, 0, 1, 4'b0001, byp_v, 32'hDEADBEEF);
    tv[17] = mk(0, 7, 32'h12345678, 4'b0000, 7, 0, 0, 4'b0000, byp_v, 32'hDEADBEEF);
    tv[18] = mk(0, 0, 32'h0,        4'b0010, 0, 7, 0, 4'b0010, byp_v, 32'h12345678);
    tv[19] = mk(0, 0, 32'h0,        4'b0000, 0, 7, 0, 4'b0000, byp_v, 32'h12345678);

    // Reset state
    rst_n = 1'b0; req_r = '0; raddr = '0; req_w = 1'b0; waddr = '0; wdata = '0;
    cycle(); cycle();
    chk("reset.ack_w", ack_w, 1'b0);
    chk("reset.ack_r", ack_r, '0);
    chk("reset.rdata", rdata, '0);
    rst_n = 1'b1;

    // Directed table: basic reads/writes, held req, r0 write, same-edge collision
    for (int i = 0; i < 20; i++) begin
      req_w = tv[i].rw; waddr = tv[i].wa; wdata = tv[i].wd;
      req_r = tv[i].rr; set_ra(0, tv[i].ra0); set_ra(1, tv[i].ra1);
      cycle();
      chk($sformatf("tv%0d.ack_w", i), ack_w, tv[i].eaw);
      chk($sformatf("tv%0d.ack_r", i), ack_r, tv[i].ear);
      chk($sformatf("tv%0d.rdata0", i), port_data(0), tv[i].ed0);
      chk($sformatf("tv%0d.rdata1", i), port_data(1), tv[i].ed1);
    end

    // Four ports read four different registers on the same edge
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hA0000000 | (32'h11 * (i + 1));
      req_w = 1'b1; waddr = AW'(10 + i); wdata = vals[i];
      cycle();
      req_w = 1'b0;
      cycle();
    end
    req_r = 4'b1111;
    for (int k = 0; k < NR; k++) set_ra(k, AW'(10 + k));
    cycle();
    chk("quad.ack_r", ack_r, 4'b1111);
    for (int k = 0; k < NR; k++) chk($sformatf("quad.rdata%0d", k), port_data(k), vals[k]);
    req_r = '0;
    cycle();
    chk("quad.release", ack_r, 4'b0000);

    // Reset while port 1 is acknowledging, req held through release
    req_r = 4'b0010; set_ra(1, 5'd13);
    cycle();
    chk("rstack.ack_r", ack_r, 4'b0010);
    chk("rstack.rdata1", port_data(1), vals[3]);
    rst_n = 1'b0;
    cycle();
    chk("rstack.rst_ack_r", ack_r, 4'b0000);
    chk("rstack.rst_ack_w", ack_w, 1'b0);
    chk("rstack.rst_rdata", rdata, '0);
    rst_n = 1'b1;
    cycle();
    chk("rstack.recapture_ack", ack_r, 4'b0010);
    chk("rstack.recapture_data", port_data(1), 32'h0);
    req_r = '0;
    cycle();
    req_r = 4'b1111;
    for (int k = 0; k < NR; k++) set_ra(k, AW'(10 + k));
    cycle();
    chk("rstack.cleared_ack", ack_r, 4'b1111);
    chk("rstack.cleared_data", rdata, '0);
    req_r = '0;
    cycle();

    // Randomized traffic on a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      req_w = $urandom_range(0, 1);
      waddr = AW'($urandom_range(0, 7));
      wdata = $urandom;
      req_r = NR'($urandom_range(0, 15));
      for (int k = 0; k < NR; k++) set_ra(k, AW'($urandom_range(0, 7)));
      cycle();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file_hs.md
# register_file_hs

Parametrised, clocked successor of the core's request-driven register file. It provides NumRead independent read ports and one write port, each with its own four-phase req/ack handshake. Read data is registered and stays stable for the whole acknowledge phase. It sits between the decode/issue stage and the execute/writeback stages. Register 0 can be hardwired to zero.

## Interface
- DataWidth, 32, register width in bits
- AddrWidth, 5, address width; depth = 2**AddrWidth
- NumRead, 2, number of read ports (1..4)
- ZeroReg, 1, when 1, register 0 always reads 0 and ignores writes
- clk_i  in  1  single clock; all state updates on the rising edge
- rst_ni  in  1  reset; synchronous, active-low
- req_r_i  in  NumRead  per-port read request, port k = bit k
- raddr_i  in  NumRead*AddrWidth  read addresses, port k = bits [k*AddrWidth +: AddrWidth]
- ack_r_o  out  NumRead  per-port read acknowledge
- rdata_o  out  NumRead*DataWidth  registered read data, port k = bits [k*DataWidth +: DataWidth]
- req_w_i  in  1  write request
- waddr_i  in  AddrWidth  write address
- wdata_i  in  DataWidth  write data
- ack_w_o  out  1  write acknowledge

## Operation
- Each port (the NumRead read ports and the write port) has its own 2-state FSM: IDLE, ACK.
- IDLE -> ACK when req is sampled high. The read port captures the data at its address into rdata; the write port commits wdata to waddr.
- In ACK, ack_o is 1. The state stays in ACK while req stays high. It returns to IDLE when req is sampled low.
- A new transaction needs req to go low and then high again (four-phase). Holding req high never causes a second access.
- Address and data inputs are sampled only on the IDLE->ACK edge. Changes to them during ACK are ignored.
- rdata for a port is held from capture until that port's next capture, including while the port is IDLE. Later writes to the same register do not change a held rdata.
- Write to address 0 with ZeroReg=1: the handshake completes normally and storage is not modified. Reading address 0 returns 0.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.
- Same-cycle write capture and read capture to the same address: the result depends on the macro (see Configuration).
- Reset (rst_ni low at an edge): all registers go to 0, all FSMs go to IDLE, all ack_o go to 0, and all rdata go to 0.
- If req is still high on the first edge after reset releases, it is treated as a new request.

## Timing
- Request edge to ack: req sampled high at edge n gives ack_o=1 and valid rdata after edge n (latency 1).
- Release: req sampled low at edge m gives ack_o=0 after edge m.
- Minimum transaction: 2 cycles. Back-to-back throughput is one transaction per 2 cycles per port.
- A write committed at edge n is visible to any read captured at edge n+1 or later.
- All outputs are registered. No combinational path exists from any input to any output.

## Configuration
- RF_WRITE_BYPASS_EN defined: when a read capture and a write commit to the same nonzero address happen on the same edge, the read captures wdata_i (new value).
- RF_WRITE_BYPASS_EN undefined: in that case the read captures the old stored value.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset, then write 0x00000001 to r4, then 0x000C0001 to r2. Read r4 on port 0 and r2 on port 1 together -> both ack_r_o bits rise 1 cycle after req; rdata port0=0x00000001, port1=0x000C0001.
- Hold req_r_i[0] high for 5 cycles on r4, and write 0xDEADBEEF to r4 during that time -> ack stays high; rdata stays 0x00000001; exactly one capture.
- Write 0xFFFFFFFF to r0 with ZeroReg=1 -> ack_w_o completes the handshake; a following read of r0 returns 0x00000000.
- Same-edge write 0x12345678 to r7 (old value 0xA5A5A5A5) and read r7 -> rdata=0x12345678 with RF_WRITE_BYPASS_EN, 0xA5A5A5A5 without.
- Assert rst_ni low while port 1 is in ACK with req high -> after the reset edge, ack=0, rdata=0, and all registers read 0. After release with req still high, a new capture occurs 1 cycle later.
- NumRead=4, all four ports read different addresses in the same cycle -> all acks rise together with the correct, independent data.
